// File: rtl/sap_ram_mar.sv
// sap_ram_mar: SAP-1 program/data memory with memory address register and a
// program-loader handshake. The loader fills memory from address 0 upward
// while prog_mode is high; otherwise the CPU controls (lm/ce/we) own the block.
// Reads are combinational onto a tri-stated bus; writes land on the rising edge.
module sap_ram_mar #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              prog_mode,
    input  logic              lm,
    input  logic              ce,
    input  logic              we,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [ADDR_W-1:0] mar,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [ADDR_W-1:0]         ptr_r;
    logic [ADDR_W-1:0]         ptr_nxt_s;
    logic [ADDR_W-1:0]         mar_r;
    logic                      ready_r;
    logic                      done_r;
    logic [DEPTH*DATA_W-1:0]   mem_r;

    logic                      accept_s;
    logic                      cpu_en_s;
    logic                      bus_oe_s;
    logic                      mem_we_s;
    logic [ADDR_W-1:0]         mem_addr_s;
    logic [DATA_W-1:0]         mem_wdata_s;

    // The CPU side only acts when the loader is fully idle and not requested.
    assign cpu_en_s = (!prog_mode) && (state_r == ST_IDLE);
    // A loader word is taken whenever the loader is in LOAD and a word is offered.
    assign accept_s = (state_r == ST_LOAD) && prog_valid;
    // Reset forces the bus released even though ce may be asserted meanwhile.
    assign bus_oe_s = clr_n && cpu_en_s && ce;

    assign bus_oe     = bus_oe_s;
    assign bus_out    = bus_oe_s ? mem_r[int'(mar_r)*DATA_W +: DATA_W] : {DATA_W{1'bz}};
    assign mar        = mar_r;
    assign prog_ready = ready_r;
    assign prog_done  = done_r;

    // Loader next-state and pointer logic.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                ptr_nxt_s = {ADDR_W{1'b0}};
                if (prog_mode) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    ptr_nxt_s = ptr_r + ADDR_W'(1);
                end else begin
                    ptr_nxt_s = ptr_r;
                end
                if (!prog_mode) begin
                    state_nxt_s = ST_IDLE;
                end else if (accept_s && (ptr_r == PTR_LAST)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (!prog_mode) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ptr_nxt_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Loader state, pointer and the registered handshake outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= {ADDR_W{1'b0}};
            ready_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            ready_r <= (state_nxt_s == ST_LOAD);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Memory write port arbitration: the loader wins; CPU writes use the current MAR.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = ptr_r;
        mem_wdata_s = prog_data;
        if (accept_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = ptr_r;
            mem_wdata_s = prog_data;
        end else if (cpu_en_s && we) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = mar_r;
            mem_wdata_s = bus_in;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Memory array, cleared as a whole by reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mem_r <= {(DEPTH*DATA_W){1'b0}};
        end else if (mem_we_s) begin
            mem_r[int'(mem_addr_s)*DATA_W +: DATA_W] <= mem_wdata_s;
        end
    end

    // Memory address register; loads only while the CPU owns the block.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mar_r <= {ADDR_W{1'b0}};
        end else if (cpu_en_s && lm) begin
            mar_r <= bus_in[ADDR_W-1:0];
        end
    end

endmodule

// File: tb/tb_sap_ram_mar.sv
// Directed testbench for sap_ram_mar: default 8x16 build plus a 16x64 build.
module tb_sap_ram_mar;

    logic        clk;
    logic        clr_n;
    logic        prog_mode, lm, ce, we, prog_valid;
    logic [7:0]  bus_in, prog_data;
    logic [7:0]  bus_out;
    logic        bus_oe, prog_ready, prog_done;
    logic [3:0]  mar;

    logic        p_prog_mode, p_lm, p_ce, p_we, p_prog_valid;
    logic [15:0] p_bus_in, p_prog_data;
    logic [15:0] p_bus_out;
    logic        p_bus_oe, p_prog_ready, p_prog_done;
    logic [5:0]  p_mar;

    int pass_cnt = 0;
    int total_cnt = 0;

    sap_ram_mar #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .clr_n(clr_n), .prog_mode(prog_mode), .lm(lm), .ce(ce), .we(we),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .mar(mar),
        .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(prog_ready), .prog_done(prog_done)
    );

    sap_ram_mar #(.DATA_W(16), .ADDR_W(6)) dut_p (
        .clk(clk), .clr_n(clr_n), .prog_mode(p_prog_mode), .lm(p_lm), .ce(p_ce), .we(p_we),
        .bus_in(p_bus_in), .bus_out(p_bus_out), .bus_oe(p_bus_oe), .mar(p_mar),
        .prog_valid(p_prog_valid), .prog_data(p_prog_data),
        .prog_ready(p_prog_ready), .prog_done(p_prog_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Load MAR with addr, then sample the bus with ce=1.
    task automatic rd(input logic [3:0] a, output logic [7:0] d, output logic oe);
        lm = 1'b1; bus_in = {4'h0, a};
        tick;
        lm = 1'b0; ce = 1'b1;
        #1;
        d = bus_out; oe = bus_oe;
        ce = 1'b0;
    endtask

    task automatic p_rd(input logic [5:0] a, output logic [15:0] d);
        p_lm = 1'b1; p_bus_in = {10'h000, a};
        tick;
        p_lm = 1'b0; p_ce = 1'b1;
        #1;
        d = p_bus_out;
        p_ce = 1'b0;
    endtask

    task automatic test_reset;
        clr_n = 1'b0; ce = 1'b1;
        repeat (2) tick;
        total_cnt++; if (bus_oe !== 1'b0) $display("FAIL rst_oe_held: got %b exp 0", bus_oe); else pass_cnt++;
        total_cnt++; if (prog_ready !== 1'b0) $display("FAIL rst_ready: got %b exp 0", prog_ready); else pass_cnt++;
        clr_n = 1'b1;
        #1;
        total_cnt++; if (bus_out !== 8'h00) $display("FAIL rst_bus: got %h exp 00", bus_out); else pass_cnt++;
        total_cnt++; if (bus_oe !== 1'b1) $display("FAIL rst_oe_ce: got %b exp 1", bus_oe); else pass_cnt++;
        total_cnt++; if (mar !== 4'h0) $display("FAIL rst_mar: got %h exp 0", mar); else pass_cnt++;
        total_cnt++; if (prog_done !== 1'b0) $display("FAIL rst_done: got %b exp 0", prog_done); else pass_cnt++;
        ce = 1'b0;
        #1;
        total_cnt++; if (bus_oe !== 1'b0) $display("FAIL rst_oe_noce: got %b exp 0", bus_oe); else pass_cnt++;
    endtask

    task automatic test_full_load;
        int acc = 0;
        int done_early = 0;
        logic [7:0] d;
        logic oe;
        prog_mode = 1'b1;
        tick;
        total_cnt++; if (prog_ready !== 1'b1) $display("FAIL load_ready_rise: got %b exp 1", prog_ready); else pass_cnt++;
        for (int i = 0; i < 17; i++) begin
            prog_valid = 1'b1;
            prog_data  = (i < 16) ? 8'h10 + 8'(i) : 8'hFF;
            if (prog_ready === 1'b1) acc++;
            if (i < 16 && prog_done !== 1'b0) done_early++;
            tick;
        end
        total_cnt++; if (acc != 16) $display("FAIL load_accepts: got %0d exp 16", acc); else pass_cnt++;
        total_cnt++; if (done_early != 0) $display("FAIL load_done_early: got %0d exp 0", done_early); else pass_cnt++;
        total_cnt++; if (prog_done !== 1'b1) $display("FAIL load_done: got %b exp 1", prog_done); else pass_cnt++;
        prog_mode = 1'b0; prog_valid = 1'b0;
        tick;
        total_cnt++; if (prog_done !== 1'b0) $display("FAIL load_done_drop: got %b exp 0", prog_done); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), d, oe);
            total_cnt++; if (d !== 8'h10 + 8'(i) || oe !== 1'b1)
                $display("FAIL load_rb[%0d]: got %h/%b exp %h/1", i, d, oe, 8'h10 + 8'(i)); else pass_cnt++;
        end
    endtask

    task automatic test_stall_abort;
        logic [7:0] d;
        logic oe;
        logic [7:0] e;
        clr_n = 1'b0; #2; clr_n = 1'b1;
        tick;
        prog_mode = 1'b1;
        tick;
        for (int i = 0; i < 9; i++) begin
            if (i == 5) begin
                prog_valid = 1'b0;
                repeat (3) tick;
                total_cnt++; if (prog_ready !== 1'b1) $display("FAIL stall_ready: got %b exp 1", prog_ready); else pass_cnt++;
            end
            prog_valid = 1'b1; prog_data = 8'h20 + 8'(i);
            tick;
        end
        prog_mode = 1'b0; prog_valid = 1'b0;
        tick;
        total_cnt++; if (prog_done !== 1'b0 || prog_ready !== 1'b0)
            $display("FAIL abort_flags: got %b%b exp 00", prog_done, prog_ready); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            e = (i < 9) ? 8'h20 + 8'(i) : 8'h00;
            rd(4'(i), d, oe);
            total_cnt++; if (d !== e) $display("FAIL abort_rb[%0d]: got %h exp %h", i, d, e); else pass_cnt++;
        end
    endtask

    task automatic test_cpu_rw;
        logic [7:0] d;
        logic oe;
        lm = 1'b1; bus_in = 8'h0A;
        tick;
        lm = 1'b0;
        total_cnt++; if (mar !== 4'hA) $display("FAIL rw_mar: got %h exp a", mar); else pass_cnt++;
        we = 1'b1; ce = 1'b1; bus_in = 8'h5C;
        #1;
        total_cnt++; if (bus_out !== 8'h00) $display("FAIL rw_prewrite: got %h exp 00", bus_out); else pass_cnt++;
        tick;
        we = 1'b0;
        #1;
        total_cnt++; if (bus_out !== 8'h5C) $display("FAIL rw_write: got %h exp 5c", bus_out); else pass_cnt++;
        ce = 1'b0; lm = 1'b1; we = 1'b1; bus_in = 8'h03;
        tick;
        lm = 1'b0; we = 1'b0;
        total_cnt++; if (mar !== 4'h3) $display("FAIL rw_lmwe_mar: got %h exp 3", mar); else pass_cnt++;
        rd(4'hA, d, oe);
        total_cnt++; if (d !== 8'h03) $display("FAIL rw_lmwe_old: got %h exp 03", d); else pass_cnt++;
        rd(4'h3, d, oe);
        total_cnt++; if (d !== 8'h23) $display("FAIL rw_lmwe_new: got %h exp 23", d); else pass_cnt++;
    endtask

    task automatic test_masking;
        logic [7:0] d;
        logic oe;
        prog_mode = 1'b1; lm = 1'b1; we = 1'b1; ce = 1'b1; bus_in = 8'h07;
        #1;
        total_cnt++; if (bus_oe !== 1'b0) $display("FAIL mask_oe: got %b exp 0", bus_oe); else pass_cnt++;
        tick;
        total_cnt++; if (mar !== 4'h3) $display("FAIL mask_mar: got %h exp 3", mar); else pass_cnt++;
        prog_valid = 1'b1; prog_data = 8'hE0;
        tick;
        prog_data = 8'hE1;
        tick;
        prog_valid = 1'b0;
        tick;
        total_cnt++; if (mar !== 4'h3 || bus_oe !== 1'b0)
            $display("FAIL mask_hold: got %h/%b exp 3/0", mar, bus_oe); else pass_cnt++;
        prog_mode = 1'b0; lm = 1'b0; we = 1'b0; ce = 1'b0;
        tick;
        rd(4'h0, d, oe);
        total_cnt++; if (d !== 8'hE0) $display("FAIL mask_ld0: got %h exp e0", d); else pass_cnt++;
        rd(4'h1, d, oe);
        total_cnt++; if (d !== 8'hE1) $display("FAIL mask_ld1: got %h exp e1", d); else pass_cnt++;
        rd(4'h3, d, oe);
        total_cnt++; if (d !== 8'h23) $display("FAIL mask_nowr3: got %h exp 23", d); else pass_cnt++;
        rd(4'h7, d, oe);
        total_cnt++; if (d !== 8'h27) $display("FAIL mask_nowr7: got %h exp 27", d); else pass_cnt++;
    endtask

    task automatic test_mid_load_reset;
        logic [7:0] d;
        logic oe;
        prog_mode = 1'b1;
        tick;
        for (int i = 0; i < 7; i++) begin
            prog_valid = 1'b1; prog_data = 8'h30 + 8'(i);
            tick;
        end
        prog_valid = 1'b0;
        #2;
        clr_n = 1'b0;
        #1;
        total_cnt++; if (prog_ready !== 1'b0 || prog_done !== 1'b0)
            $display("FAIL mrst_flags: got %b%b exp 00", prog_ready, prog_done); else pass_cnt++;
        prog_mode = 1'b0;
        #1;
        clr_n = 1'b1;
        tick;
        total_cnt++; if (prog_ready !== 1'b0) $display("FAIL mrst_idle: got %b exp 0", prog_ready); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), d, oe);
            total_cnt++; if (d !== 8'h00 || oe !== 1'b1)
                $display("FAIL mrst_rb[%0d]: got %h/%b exp 00/1", i, d, oe); else pass_cnt++;
        end
    endtask

    task automatic test_param;
        int acc = 0;
        int done_early = 0;
        logic [15:0] d;
        logic [15:0] e;
        p_prog_mode = 1'b1;
        tick;
        total_cnt++; if (p_prog_ready !== 1'b1) $display("FAIL p_ready: got %b exp 1", p_prog_ready); else pass_cnt++;
        for (int i = 0; i < 64; i++) begin
            p_prog_valid = 1'b1;
            p_prog_data  = 16'h1000 + 16'(i * 259);
            if (p_prog_ready === 1'b1) acc++;
            if (p_prog_done !== 1'b0) done_early++;
            tick;
        end
        total_cnt++; if (acc != 64) $display("FAIL p_accepts: got %0d exp 64", acc); else pass_cnt++;
        total_cnt++; if (done_early != 0) $display("FAIL p_done_early: got %0d exp 0", done_early); else pass_cnt++;
        total_cnt++; if (p_prog_done !== 1'b1) $display("FAIL p_done: got %b exp 1", p_prog_done); else pass_cnt++;
        p_prog_mode = 1'b0; p_prog_valid = 1'b0;
        tick;
        for (int i = 0; i < 64; i++) begin
            e = 16'h1000 + 16'(i * 259);
            p_rd(6'(i), d);
            total_cnt++; if (d !== e || p_mar !== 6'(i))
                $display("FAIL p_rb[%0d]: got %h@%0d exp %h", i, d, p_mar, e); else pass_cnt++;
        end
    endtask

    initial begin
        clr_n = 1'b0; prog_mode = 1'b0; lm = 1'b0; ce = 1'b0; we = 1'b0;
        bus_in = 8'h00; prog_valid = 1'b0; prog_data = 8'h00;
        p_prog_mode = 1'b0; p_lm = 1'b0; p_ce = 1'b0; p_we = 1'b0;
        p_bus_in = 16'h0000; p_prog_valid = 1'b0; p_prog_data = 16'h0000;
        test_reset;
        test_full_load;
        test_stall_abort;
        test_cpu_rw;
        test_masking;
        test_mid_load_reset;
        test_param;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sap_ram_mar.md
# sap_ram_mar

Parametrised program/data memory for the SAP-1 datapath. It combines the memory address register (MAR), a DATA_W x 2^ADDR_W word array with combinational bus read and synchronous bus write, and a program-loader handshake. The loader fills memory from address 0 upward before the CPU runs. The block sits on the shared W-bus in place of the fixed 16x8 read-only RAM, and the controller drives its lm/ce/we control lines.

## Interface
- DATA_W, 8: word width; bus width.
- ADDR_W, 4: address width; depth = 2^ADDR_W words.

- clk  in  1  system clock; all state updates on rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- prog_mode  in  1  1 = loader owns memory; CPU controls ignored.
- lm  in  1  load MAR from bus_in[ADDR_W-1:0].
- ce  in  1  drive mem[MAR] onto bus_out.
- we  in  1  write bus_in to mem[MAR].
- bus_in  in  DATA_W  W-bus value.
- bus_out  out  DATA_W  mem[MAR] when driving, else high-Z.
- bus_oe  out  1  1 when bus_out is driven.
- mar  out  ADDR_W  current MAR (debug/monitor).
- prog_valid  in  1  loader word available.
- prog_data  in  DATA_W  loader word.
- prog_ready  out  1  block accepts a loader word this cycle.
- prog_done  out  1  all 2^ADDR_W words loaded.

## Operation
- Reset (clr_n=0, asynchronous) sets the following:
  - MAR=0 and every memory word=0.
  - Loader state=IDLE and load pointer=0.
  - prog_ready=0, prog_done=0, bus_oe=0, bus_out=Z.
- CPU mode (prog_mode=0, state IDLE):
  - lm: MAR <= bus_in[ADDR_W-1:0] at the edge.
  - we: mem[MAR] <= bus_in at the edge, using the MAR value before any same-cycle lm update.
  - ce: bus_oe=1, bus_out=mem[MAR] combinationally; otherwise bus_out=Z.
  - we and lm together: write goes to the old address; MAR updates at the same edge.
  - ce and we together: bus_out shows pre-write contents until the edge.
- Loader FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on a clock edge with prog_mode=1; pointer <= 0.
  - LOAD: prog_ready=1. Each cycle with prog_valid & prog_ready, mem[ptr] <= prog_data and ptr increments.
  - LOAD -> DONE on the accepted write at ptr = 2^ADDR_W-1.
  - DONE: prog_ready=0, prog_done=1; further prog_valid is ignored.
  - Any state -> IDLE on an edge with prog_mode=0. prog_ready and prog_done drop to 0.
  - Words written before an abort are retained.
- When prog_mode=1 or state≠IDLE:
  - lm, ce and we are ignored; bus_oe=0; bus_out=Z; MAR holds.
- Pointer wrap is impossible: DONE is entered instead.
- prog_valid while not ready is dropped, not queued.

## Timing
- Read latency: combinational; bus_out follows MAR/ce/memory within the same cycle.
- Write latency: the written word is visible on bus_out (with ce=1) in the cycle after the write edge.
- MAR load: the new address takes effect in the cycle after the lm edge.
- Loader throughput: one word per clock.
- Loader timeline: prog_ready rises one edge after prog_mode is sampled high. A full 2^ADDR_W-word load needs at least 2^ADDR_W accepted cycles.
- prog_done rises on the edge that accepts the last word.
- Reset mid-load: clears memory and returns to IDLE immediately, without waiting for a clock. After release, the loader re-enters LOAD only on an edge with prog_mode=1.
- Returning from DONE/LOAD to IDLE takes one edge. CPU controls are honoured from the following cycle.

## Test plan
- Reset values:
  - Stimulus: clr_n=0 for 2 cycles, then release; ce=1 with MAR=0.
  - Response: bus_out=8'h00, bus_oe=1, mar=0, prog_ready=0, prog_done=0.
  - With ce=0: bus_out=Z.
- Full program load:
  - Stimulus: prog_mode=1; stream 16 words prog_data = 8'h10+i with prog_valid held high.
  - Response: prog_ready=1 for exactly 16 accepts; prog_done=1 after the 16th accept.
  - Then prog_mode=0, lm=1 with bus_in=i, then ce=1: each address reads 8'h10+i.
- Loader stall and abort:
  - Stimulus: gap prog_valid low for 3 cycles after 5 words, then drop prog_mode after 9 words.
  - Response: addresses 0-8 hold the loaded values, 9-15 hold 0, and prog_done stays 0.
- CPU write/read:
  - Stimulus: lm with bus_in=4'hA, then we with bus_in=8'h5C, then ce.
  - Response: bus_out=8'h5C one cycle after the write edge.
  - Stimulus: lm and we in the same cycle with bus_in=8'h03, starting from MAR=4'hA.
  - Response: mem[A]=8'h03 and mar=3.
- Control masking:
  - Stimulus: prog_mode=1 with lm, we and ce asserted.
  - Response: MAR is unchanged, no memory change except loader writes, bus_oe=0.
- Mid-load reset:
  - Stimulus: pulse clr_n low between edges after 7 words are loaded.
  - Response: immediate state=IDLE, prog_ready=0, all memory 0.
- Parametrised build:
  - Stimulus: DATA_W=16, ADDR_W=6; full load and readback.
  - Response: 64 loaded 16-bit words read back correctly; prog_done asserts after accept 64.
